// File: rtl/sram_dff_dp.sv
// Flip-flop based simple dual-port memory with byte-enable writes, write-first read and an init engine.
// Define SRAM_DFF_PARITY_EN to add per-byte even parity storage, rd_perr_o and inj_perr_i.
module sram_dff_dp #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 3,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   wa_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    input  logic [DATA_W-1:0]   wd_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   ra_i,
    output logic [DATA_W-1:0]   rd_o,
    output logic                rd_valid_o,
    input  logic                init_req_i,
    output logic                busy_o
`ifdef SRAM_DFF_PARITY_EN
    ,
    input  logic                inj_perr_i,
    output logic                rd_perr_o
`endif
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {IDLE, INIT} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   initCnt_q, initCnt_d;
    logic                initLast, doInit, doWrite, doRead;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   rdData_q, rdData_d;
    logic                rdValid_q, rdValid_d;

    assign initLast = (initCnt_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init_req_i) state_d = INIT;
            INIT:    if (initLast)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A request sampled on the same edge as an init trigger is dropped.
    always_comb begin
        busy_o    = (state_q == INIT);
        doInit    = (state_q == INIT);
        doWrite   = (state_q == IDLE) && !init_req_i && we_i;
        doRead    = (state_q == IDLE) && !init_req_i && re_i;
        initCnt_d = (state_q == INIT) ? initCnt_q + ADDR_W'(1) : '0;
    end

    // Next memory image; reads index it so same-address reads see the merged word.
    always_comb begin
        mem_d = mem_q;
        if (doInit) begin
            mem_d[initCnt_q] = INIT_VAL;
        end else if (doWrite) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe_i[b]) mem_d[wa_i][8*b +: 8] = wd_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdValid_d = doRead;
        rdData_d  = doRead ? mem_d[ra_i] : rdData_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    assign rd_o       = rdData_q;
    assign rd_valid_o = rdValid_q;

`ifdef SRAM_DFF_PARITY_EN
    logic [NBYTES-1:0] par_q [DEPTH];
    logic [NBYTES-1:0] par_d [DEPTH];
    logic              rdPerr_q, rdPerr_d;

    // Stored bit makes byte plus parity even; injection flips it for written bytes.
    always_comb begin
        par_d = par_q;
        if (doInit) begin
            for (int b = 0; b < NBYTES; b++) par_d[initCnt_q][b] = ^INIT_VAL[8*b +: 8];
        end else if (doWrite) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe_i[b]) par_d[wa_i][b] = (^wd_i[8*b +: 8]) ^ inj_perr_i;
            end
        end
    end

    always_comb begin
        rdPerr_d = 1'b0;
        if (doRead) begin
            for (int b = 0; b < NBYTES; b++) begin
                if ((^mem_d[ra_i][8*b +: 8]) != par_d[ra_i][b]) rdPerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= '0;
            rdPerr_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            rdPerr_q <= rdPerr_d;
        end
    end

    assign rd_perr_o = rdPerr_q;
`endif

endmodule

// File: tb/tb_sram_dff_dp.sv
// Self-checking bench for sram_dff_dp: directed scenarios plus random traffic against a behavioural model.
module tb_sram_dff_dp;

   localparam int          DW    = 32;
   localparam int          AW    = 3;
   localparam int          DEPTH = 8;
   localparam int          NB    = 4;
   localparam logic [31:0] IV    = 32'hCAFEF00D;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] wa = '0;
   logic [NB-1:0] wbe = '0;
   logic [DW-1:0] wd = '0;
   logic          re = 1'b0;
   logic [AW-1:0] ra = '0;
   logic [DW-1:0] rdOut;
   logic          rdValidOut;
   logic          initReq = 1'b0;
   logic          busyOut;
   logic          injPerr = 1'b0;
   logic          rdPerrOut;

   int checks = 0;
   int errors = 0;
   logic checkEn = 1'b0;

   logic [DW-1:0] mMem [DEPTH];
   logic [NB-1:0] mPar [DEPTH];
   logic [DW-1:0] expRd;
   logic          expValid;
   logic          expBusy;
   logic          expPerr;
   int            initLeft;

   sram_dff_dp #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(IV)) dut (
      .clk(clk), .resetn(resetn),
      .we_i(we), .wa_i(wa), .wbe_i(wbe), .wd_i(wd),
      .re_i(re), .ra_i(ra),
      .rd_o(rdOut), .rd_valid_o(rdValidOut),
      .init_req_i(initReq), .busy_o(busyOut)
`ifdef SRAM_DFF_PARITY_EN
      , .inj_perr_i(injPerr), .rd_perr_o(rdPerrOut)
`endif
   );

`ifndef SRAM_DFF_PARITY_EN
   assign rdPerrOut = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [NB-1:0] parOf(input logic [DW-1:0] w);
      logic [NB-1:0] p;
      for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
      return p;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: memory as a plain array, init as a countdown of remaining words.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mMem[i] = '0;
            mPar[i] = '0;
         end
         expRd = '0; expValid = 1'b0; expBusy = 1'b0; expPerr = 1'b0; initLeft = 0;
      end else if (expBusy) begin
         mMem[DEPTH - initLeft] = IV;
         mPar[DEPTH - initLeft] = parOf(IV);
         initLeft = initLeft - 1;
         if (initLeft == 0) expBusy = 1'b0;
         expValid = 1'b0;
         expPerr = 1'b0;
      end else if (initReq) begin
         expBusy = 1'b1;
         initLeft = DEPTH;
         expValid = 1'b0;
         expPerr = 1'b0;
      end else begin
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (wbe[b]) begin
                  mMem[wa][8*b +: 8] = wd[8*b +: 8];
                  mPar[wa][b] = (^wd[8*b +: 8]) ^ injPerr;
               end
            end
         end
         expValid = re;
         expPerr = 1'b0;
         if (re) begin
            expRd = mMem[ra];
`ifdef SRAM_DFF_PARITY_EN
            expPerr = (parOf(mMem[ra]) != mPar[ra]);
`endif
         end
      end
   end

   // Cycle-by-cycle comparison on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("rd_valid", {31'b0, rdValidOut}, {31'b0, expValid});
         checkOutput("busy", {31'b0, busyOut}, {31'b0, expBusy});
         checkOutput("rd", rdOut, expRd);
         checkOutput("rd_perr", {31'b0, rdPerrOut}, {31'b0, expPerr});
      end
   end

   task automatic applyStimulus(input logic iWe, input logic [AW-1:0] iWa, input logic [NB-1:0] iWbe,
                                input logic [DW-1:0] iWd, input logic iRe, input logic [AW-1:0] iRa,
                                input logic iInit, input logic iInj);
      we = iWe; wa = iWa; wbe = iWbe; wd = iWd; re = iRe; ra = iRa; initReq = iInit; injPerr = iInj;
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0; initReq = 1'b0; injPerr = 1'b0;
   endtask

   initial begin
      int busyCnt;
      #1 checkEn = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // Reset contents and back-to-back reads.
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, 1'b0);
         checkOutput("t1 rd", rdOut, 32'h0);
         checkOutput("t1 valid", {31'b0, rdValidOut}, 32'h1);
         checkOutput("t1 busy", {31'b0, busyOut}, 32'h0);
      end
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("t1 valid drop", {31'b0, rdValidOut}, 32'h0);
      checkOutput("t1 rd hold", rdOut, 32'h0);

      // Partial byte-enable merge.
      applyStimulus(1'b1, 3'd5, 4'hF, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd5, 4'h5, 32'h11223344, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd5, 1'b0, 1'b0);
      checkOutput("t2 rd", rdOut, 32'hDE22BE44);
      checkOutput("t2 model", expRd, 32'hDE22BE44);

      // Write-first on the same address and edge.
      applyStimulus(1'b1, 3'd2, 4'hF, 32'h12345678, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd2, 4'hC, 32'hA5A5A5A5, 1'b1, 3'd2, 1'b0, 1'b0);
      checkOutput("t3 rd", rdOut, 32'hA5A55678);
      checkOutput("t3 model", expRd, 32'hA5A55678);

      // Init engine: requests ignored while busy.
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      busyCnt = busyOut ? 1 : 0;
      for (int k = 0; k < 20 && busyOut; k++) begin
         applyStimulus(1'b1, 3'd3, 4'hF, 32'h11111111, 1'b1, 3'd3, 1'b0, 1'b0);
         checkOutput("t4 valid busy", {31'b0, rdValidOut}, 32'h0);
         if (busyOut) busyCnt++;
      end
      checkOutput("t4 busy cycles", busyCnt, 32'd8);
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, 1'b0);
         checkOutput("t4 rd", rdOut, 32'hCAFEF00D);
      end

      // Reset in the middle of init.
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("t5 busy before", {31'b0, busyOut}, 32'h1);
      #1 resetn = 1'b0;
      #1;
      checkOutput("t5 busy", {31'b0, busyOut}, 32'h0);
      checkOutput("t5 valid", {31'b0, rdValidOut}, 32'h0);
      @(posedge clk);
      #3 resetn = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, 1'b0);
         checkOutput("t5 rd", rdOut, 32'h0);
      end

`ifdef SRAM_DFF_PARITY_EN
      applyStimulus(1'b1, 3'd1, 4'hF, 32'h000000FF, 1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd1, 1'b0, 1'b0);
      checkOutput("t6 rd", rdOut, 32'h000000FF);
      checkOutput("t6 perr", {31'b0, rdPerrOut}, 32'h1);
      applyStimulus(1'b1, 3'd1, 4'hF, 32'h000000FF, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd1, 1'b0, 1'b0);
      checkOutput("t6 perr clean", {31'b0, rdPerrOut}, 32'h0);
`endif

      // Random traffic against the model.
      repeat (400) begin
         applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), NB'($urandom), $urandom,
                       1'($urandom_range(0, 1)), AW'($urandom),
                       ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
      end

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_dff_dp.md
Name: sram_dff_dp

Overview:
Parametrised, flip-flop based, simple dual-port memory: one synchronous write port and one registered read port. Adds byte-enable writes, a read-valid handshake, write-first bypass and a sequential memory-initialise engine. Used as a small register file or scratch buffer between datapath blocks where a macro SRAM is not justified.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.
INIT_VAL, 0, DATA_W-bit value written to every word by the init engine.

Ports:
clk  in  1  clock; all state changes on rising edge.
resetn  in  1  reset, asynchronous, active-low.
we  in  1  write request.
wa  in  ADDR_W  write address.
wbe  in  DATA_W/8  byte enables; bit i enables byte [8i+7:8i].
wd  in  DATA_W  write data.
re  in  1  read request.
ra  in  ADDR_W  read address.
rd  out  DATA_W  read data, registered.
rd_valid  out  1  rd holds the data for the read accepted in the previous cycle.
init_req  in  1  start the initialise sequence (level-sampled).
busy  out  1  init engine active; all requests are ignored while high.

Behaviour:
- Reset (resetn=0, async): all words = 0; rd = 0; rd_valid = 0; busy = 0; FSM = IDLE; init counter = 0.
- Write: in IDLE, if we=1 at an edge, each byte i with wbe[i]=1 of word[wa] takes wd byte i. Bytes with wbe[i]=0 are unchanged. we=1 with wbe=0 is a no-op.
- Read: in IDLE, if re=1 at edge N, then rd = word[ra] and rd_valid = 1 after edge N. Latency is 1 cycle.
- re=0 at an edge: rd_valid = 0 after that edge, and rd holds its last value.
- Back-to-back reads are accepted every cycle.
- Read-during-write, same address, same edge: write-first. rd returns the merged new word, i.e. enabled bytes from wd and the other bytes from old contents. Different addresses are independent.
- FSM states:
  - IDLE: serves reads and writes. If init_req=1 at an edge, go to INIT, set counter = 0 and busy = 1. A we/re sampled on that same edge is dropped and rd_valid = 0.
  - INIT: each cycle word[counter] = INIT_VAL and counter increments. When counter reaches DEPTH-1, that word is written and the FSM returns to IDLE with busy = 0. INIT lasts exactly DEPTH cycles.
  - In INIT, we, re and init_req are ignored; rd_valid = 0 and rd holds its value.
- init_req still high on return to IDLE re-triggers INIT on the next edge.
- Counter width is ADDR_W. Terminal detection uses the counter value, not a wrap.
- Reset asserted mid-INIT aborts immediately: all words = 0 (not INIT_VAL), FSM = IDLE, busy = 0.
- Address space is exactly DEPTH, so no out-of-range case exists.

Optional Feature:
SRAM_DFF_PARITY_EN
- Defined:
  - Each word stores DATA_W/8 extra even-parity bits, one per byte, updated with that byte on write and on init.
  - Adds output rd_perr (1 bit), registered alongside rd. It is 1 when any byte of the read word mismatches its stored parity.
  - Adds input inj_perr (1 bit). When 1 during a write, stored parity of every written byte is inverted (error injection for test).
  - Reset clears parity bits to 0, which is consistent with zero data.
  - rd_perr is 0 whenever rd_valid is 0.
- Undefined: no parity storage, and the rd_perr and inj_perr ports do not exist.

Test Plan:
1. Reset, then read addresses 0..7 back-to-back -> rd_valid=1 from the cycle after the first re; rd=0 for all; busy=0.
2. Write wa=5, wd=0xDEADBEEF, wbe=0xF; then write wa=5, wd=0x11223344, wbe=0x5; read ra=5 -> rd=0xDE22BE44 one cycle after re.
3. Same edge: we wa=2 wd=0xA5A5A5A5 wbe=0xC, plus re ra=2, with word[2]=0x12345678 -> rd=0xA5A55678 next cycle (write-first).
4. INIT_VAL=0xCAFEF00D, pulse init_req one cycle -> busy=1 for exactly 8 cycles; a write to addr 3 issued during busy is dropped; re issued during busy gives rd_valid=0; afterwards all 8 words read 0xCAFEF00D.
5. Assert resetn=0 during INIT cycle 4 -> busy=0 and rd_valid=0 immediately; after release all words read 0.
6. (SRAM_DFF_PARITY_EN) Write addr 1 wd=0x000000FF with inj_perr=1, then read -> rd=0x000000FF, rd_perr=1. Rewrite with inj_perr=0 and read -> rd_perr=0.
